// File: rtl/gtech_ld_loader.sv
// Write sequencer for a bank of transparent latches: data set up before gate, held after it.
// Optional bank clear via LD_CD is compiled in with GTECH_LD_LOADER_CLR_EN.
module gtech_ld_loader #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned GATE_CYCLES = 2,
  parameter int unsigned AW          = $clog2(DEPTH)
) (
  input  logic             CP,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [AW-1:0]    IN_ADDR,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             CLR_REQ,
  output logic [WIDTH-1:0] LD_D,
  output logic [DEPTH-1:0] LD_G,
  output logic             LD_CD,
  output logic             BUSY
);

  // Counter holds GATE_CYCLES-1 for the gate phase and 1 for the clear phase.
  localparam int unsigned CW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StGate, StHold, StClear} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] ld_d_q, ld_d_d;
  logic [DEPTH-1:0] ld_g_q, ld_g_d;
  logic [DEPTH-1:0] gate_sel;
  logic             ld_cd_q, ld_cd_d;
  logic             busy_q, busy_d;
  logic             clr_go;
  logic             accept;

`ifdef GTECH_LD_LOADER_CLR_EN
  assign clr_go = CLR_REQ;
`else
  logic unused_clr;
  assign unused_clr = CLR_REQ;
  assign clr_go     = 1'b0;
`endif

  assign IN_READY = (state_q == StIdle) && !clr_go;
  assign accept   = IN_READY && IN_VALID;

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      ld_d_q  <= '0;
      ld_g_q  <= '0;
      ld_cd_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ld_d_q  <= ld_d_d;
      ld_g_q  <= ld_g_d;
      ld_cd_q <= ld_cd_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_go) begin
          state_d = StClear;
          cnt_d   = CW'(1);
        end else if (IN_VALID) begin
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d = StGate;
        cnt_d   = CW'(GATE_CYCLES - 1);
      end
      StGate: begin
        if (cnt_q == '0) state_d = StHold;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StHold:  state_d = StIdle;
      StClear: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the pins come straight from flops.
  always_comb begin
    ld_d_d = ld_d_q;
    addr_d = addr_q;
    if (accept) begin
      ld_d_d = IN_DATA;
      addr_d = IN_ADDR;
    end
    gate_sel = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      gate_sel[i] = (addr_q == AW'(i));
    end
    ld_g_d  = (state_d == StGate) ? gate_sel : '0;
    ld_cd_d = (state_d != StClear);
    busy_d  = (state_d != StIdle);
  end

  assign LD_D  = ld_d_q;
  assign LD_G  = ld_g_q;
  assign LD_CD = ld_cd_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_gtech_ld_loader.sv
// Randomized bench for gtech_ld_loader against an event/offset timing model.
module tb_gtech_ld_loader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int GC    = 2;
  localparam int AW    = $clog2(DEPTH);
`ifdef GTECH_LD_LOADER_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic             cp = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    in_addr;
  logic [WIDTH-1:0] in_data;
  logic             clr_req;
  logic [WIDTH-1:0] ld_d;
  logic [DEPTH-1:0] ld_g;
  logic             ld_cd;
  logic             busy;

  gtech_ld_loader #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .GATE_CYCLES (GC)
  ) dut (
    .CP       (cp),
    .RST      (rst),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .IN_ADDR  (in_addr),
    .IN_DATA  (in_data),
    .CLR_REQ  (clr_req),
    .LD_D     (ld_d),
    .LD_G     (ld_g),
    .LD_CD    (ld_cd),
    .BUSY     (busy)
  );

  always #5 cp = ~cp;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: last event (1 = write, 2 = clear) and the edge it was accepted on.
  int edge_n   = 0;
  int ev_edge  = 0;
  int ev_kind  = 0;
  int ev_addr  = 0;
  int exp_data = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_idle();
    int j;
    j = edge_n - ev_edge;
    if (ev_kind == 1) return j >= GC + 2;
    if (ev_kind == 2) return j >= 2;
    return 1'b1;
  endfunction

  function automatic bit exp_ready();
    return model_idle() && !(CLR_EN && clr_req);
  endfunction

  task automatic model_reset();
    edge_n   = 0;
    ev_edge  = 0;
    ev_kind  = 0;
    exp_data = 0;
  endtask

  task automatic model_edge();
    if (model_idle()) begin
      if (CLR_EN && clr_req) begin
        ev_kind = 2;
        ev_edge = edge_n + 1;
      end else if (in_valid) begin
        ev_kind  = 1;
        ev_edge  = edge_n + 1;
        ev_addr  = int'(in_addr);
        exp_data = int'(in_data);
      end
    end
    edge_n++;
  endtask

  task automatic check_outputs();
    int j;
    logic [31:0] g;
    j = edge_n - ev_edge;
    g = '0;
    if (ev_kind == 1 && j >= 1 && j <= GC && ev_addr < DEPTH) g = 32'd1 << ev_addr;
    check("ld_d", 32'(ld_d), 32'(exp_data));
    check("ld_g", 32'(ld_g), g);
    check("ld_cd", 32'(ld_cd), 32'(!(ev_kind == 2 && j < 2)));
    check("busy", 32'(busy), 32'(!model_idle()));
    check("gate_onehot", 32'($countones(ld_g) <= 1), 32'd1);
  endtask

  task automatic drive_random();
    in_valid = ($urandom_range(0, 2) != 0);
    clr_req  = ($urandom_range(0, 9) == 0);
    in_addr  = AW'($urandom_range(0, DEPTH - 1));
    in_data  = WIDTH'($urandom);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    clr_req  = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    model_reset();
    @(negedge cp);
    check("rst_ld_d", 32'(ld_d), 32'd0);
    check("rst_ld_g", 32'(ld_g), 32'd0);
    check("rst_ld_cd", 32'(ld_cd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #2 rst = 1'b0;
    #1 check("cd_before_edge", 32'(ld_cd), 32'd0);
    drive_random();

    for (int cyc = 0; cyc < 2000; cyc++) begin
      #1 check("in_ready", 32'(in_ready), 32'(exp_ready()));
      if (cyc % 300 == 150) begin
        // Asynchronous reset mid-cycle, wherever the sequence happens to be.
        #1 rst = 1'b1;
        #1;
        check("arst_ld_g", 32'(ld_g), 32'd0);
        check("arst_ld_cd", 32'(ld_cd), 32'd0);
        check("arst_ld_d", 32'(ld_d), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge cp);
        @(negedge cp);
        #2 rst = 1'b0;
        #1;
        check("arst_cd_hold", 32'(ld_cd), 32'd0);
        check("arst_ready", 32'(in_ready), 32'(exp_ready()));
      end
      @(posedge cp);
      model_edge();
      @(negedge cp);
      check_outputs();
      drive_random();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
